// File: rtl/lsu_v2_if.sv
// Memory-side bus of the load/store unit: one read channel and one write channel,
// each with a valid/ready pair.
interface lsu_v2_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  mem_read_valid;
  logic [ADDR_WIDTH-1:0] mem_read_address;
  logic                  mem_read_ready;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  mem_write_valid;
  logic [ADDR_WIDTH-1:0] mem_write_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/lsu_v2.sv
// Per-thread load/store unit: issues one memory read or write per core REQUEST,
// waits for the matching ready with an optional timeout, reports result until UPDATE.
module lsu_v2 #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            core_state,
  input  logic                  decoded_mem_read_enable,
  input  logic                  decoded_mem_write_enable,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  lsu_v2_if.master              mem,
  output logic [2:0]            lsu_state,
  output logic [DATA_WIDTH-1:0] lsu_out,
  output logic                  lsu_error
);

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam int         CNT_W        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQUESTING = 3'd1,
    WAITING    = 3'd2,
    DONE       = 3'd3,
    ERROR      = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  err_q, err_d;
  logic                  ready_hit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_d      = out_q;
    err_d      = err_q;
    // Only the channel of the latched op can complete it.
    ready_hit  = op_write_q ? mem.mem_write_ready : mem.mem_read_ready;

    unique case (state_q)
      IDLE: begin
        if (core_state == CORE_REQUEST) begin
          if (decoded_mem_read_enable && decoded_mem_write_enable) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
            op_write_d = decoded_mem_write_enable;
            addr_d     = rs;
            data_d     = rt;
            err_d      = 1'b0;
            state_d    = REQUESTING;
          end
        end
      end
      REQUESTING: begin
        cnt_d = '0;
        if (op_write_q) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = addr_q;
          wr_data_d  = data_q;
        end else begin
          rd_valid_d = 1'b1;
          rd_addr_d  = addr_q;
        end
        state_d = WAITING;
      end
      WAITING: begin
        if (ready_hit) begin
          if (!op_write_q) out_d = mem.mem_read_data;
          rd_valid_d = 1'b0;
          wr_valid_d = 1'b0;
          state_d    = DONE;
        end else if (TIMEOUT_CYCLES > 0) begin
          if (cnt_q != CNT_LIMIT) cnt_d = cnt_q + 1'b1;
          // Abort on the edge where the count reaches the limit; ready above takes priority.
          if (cnt_d == CNT_LIMIT) begin
            rd_valid_d = 1'b0;
            wr_valid_d = 1'b0;
            err_d      = 1'b1;
            state_d    = ERROR;
          end
        end
      end
      DONE, ERROR: begin
        if (core_state == CORE_UPDATE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
    end else if (enable) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  assign mem.mem_read_valid    = rd_valid_q;
  assign mem.mem_read_address  = rd_addr_q;
  assign mem.mem_write_valid   = wr_valid_q;
  assign mem.mem_write_address = wr_addr_q;
  assign mem.mem_write_data    = wr_data_q;
  assign lsu_state             = state_q;
  assign lsu_out               = out_q;
  assign lsu_error             = err_q;

endmodule

// File: tb/tb_lsu_v2.sv
// Directed-plus-random bench for lsu_v2; expectations come from a transaction-level
// model (valid length, final state, lsu_out/lsu_error) computed from ready delay and timeout.
module tb_lsu_v2;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 4;
  localparam logic [2:0] REQ = 3'b011;
  localparam logic [2:0] UPD = 3'b110;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic [2:0]    core_state = 3'd0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] rs = '0;
  logic [DW-1:0] rt = '0;
  logic [2:0]    lsu_state;
  logic [DW-1:0] lsu_out;
  logic          lsu_error;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_out = '0;
  logic          exp_err = 1'b0;

  lsu_v2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  lsu_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .rt                       (rt),
    .mem                      (bus),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out),
    .lsu_error                (lsu_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(lsu_state), 0);
    check({tag, "_rvalid"}, 32'(bus.mem_read_valid), 0);
    check({tag, "_raddr"}, 32'(bus.mem_read_address), 0);
    check({tag, "_wvalid"}, 32'(bus.mem_write_valid), 0);
    check({tag, "_waddr"}, 32'(bus.mem_write_address), 0);
    check({tag, "_wdata"}, 32'(bus.mem_write_data), 0);
    check({tag, "_out"}, 32'(lsu_out), 0);
    check({tag, "_err"}, 32'(lsu_error), 0);
  endtask

  // One complete transaction. k = valid cycles the memory waits before answering.
  task automatic do_op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int k, input logic [DW-1:0] rdata, input int freeze_at);
    int   cycles = 0;
    bit   seen_other = 1'b0;
    bit   completes;
    int   exp_cycles;
    logic v;
    completes  = (k < TO);
    exp_cycles = completes ? k + 1 : TO;

    @(negedge clk);
    core_state = REQ; rd_en = !wr; wr_en = wr; rs = a; rt = d;
    @(negedge clk);
    exp_err = 1'b0;
    check("accept_state", 32'(lsu_state), 1);
    check("accept_err_clr", 32'(lsu_error), 32'(exp_err));
    core_state = 3'($urandom_range(0, 2));

    for (int c = 0; c < 64; c++) begin
      v = wr ? bus.mem_write_valid : bus.mem_read_valid;
      if (wr ? bus.mem_read_valid : bus.mem_write_valid) seen_other = 1'b1;
      if (v) begin
        cycles++;
        if (wr) begin
          check("wr_addr", 32'(bus.mem_write_address), 32'(a));
          check("wr_data", 32'(bus.mem_write_data), 32'(d));
        end else begin
          check("rd_addr", 32'(bus.mem_read_address), 32'(a));
        end
      end else if (cycles > 0) begin
        break;
      end
      if (freeze_at > 0 && v && cycles == freeze_at) begin
        enable = 1'b0;
        bus.mem_read_ready = 1'b1; bus.mem_write_ready = 1'b1;
        bus.mem_read_data = DW'($urandom);
        repeat (5) begin
          @(negedge clk);
          check("freeze_state", 32'(lsu_state), 2);
          check("freeze_valid", 32'(wr ? bus.mem_write_valid : bus.mem_read_valid), 1);
        end
        enable = 1'b1;
      end
      if (wr) begin
        bus.mem_write_ready = v && (cycles == k + 1);
        bus.mem_read_ready  = 1'($urandom);
        bus.mem_read_data   = DW'($urandom);
      end else begin
        bus.mem_read_ready  = v && (cycles == k + 1);
        bus.mem_read_data   = (v && (cycles == k + 1)) ? rdata : DW'($urandom);
        bus.mem_write_ready = 1'($urandom);
      end
      rs = AW'($urandom); rt = DW'($urandom);
      rd_en = 1'($urandom); wr_en = 1'($urandom);
      @(negedge clk);
    end
    bus.mem_read_ready = 1'b0; bus.mem_write_ready = 1'b0;

    if (completes) begin
      if (!wr) exp_out = rdata;
    end else begin
      exp_err = 1'b1;
    end
    check("valid_cycles", 32'(cycles), 32'(exp_cycles));
    check("other_channel", 32'(seen_other), 0);
    check("end_state", 32'(lsu_state), completes ? 3 : 4);
    check("lsu_out", 32'(lsu_out), 32'(exp_out));
    check("lsu_error", 32'(lsu_error), 32'(exp_err));
    @(negedge clk);
    check("hold_state", 32'(lsu_state), completes ? 3 : 4);
    core_state = UPD;
    @(negedge clk);
    core_state = 3'd0;
    check("update_idle", 32'(lsu_state), 0);
    check("err_persist", 32'(lsu_error), 32'(exp_err));
  endtask

  initial begin
    bus.mem_read_ready = 1'b0; bus.mem_read_data = '0; bus.mem_write_ready = 1'b0;
    #1 reset = 1'b0;
    #1 check_all_zero("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rel_state", 32'(lsu_state), 0);
    check("rel_rvalid", 32'(bus.mem_read_valid), 0);

    // No request: decoded enable without REQUEST, REQUEST without decoded enable.
    core_state = 3'b010; rd_en = 1'b1; wr_en = 1'b1;
    @(negedge clk);
    check("noreq_state", 32'(lsu_state), 0);
    core_state = REQ; rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check("noen_state", 32'(lsu_state), 0);
    check("noen_rvalid", 32'(bus.mem_read_valid), 0);
    core_state = 3'd0;

    do_op(1'b0, 8'h10, 8'h00, 3, 8'hA5, 0);
    do_op(1'b0, 8'h33, 8'h00, 0, 8'h3C, 0);
    do_op(1'b1, 8'h20, 8'h5C, 2, 8'h00, 0);
    do_op(1'b0, 8'h40, 8'h00, 20, 8'h99, 0);
    do_op(1'b1, 8'h41, 8'h12, 20, 8'h00, 0);
    do_op(1'b0, 8'h50, 8'h00, TO - 1, 8'h7E, 0);

    // Both decoded enables: straight to ERROR, no request on either channel.
    @(negedge clk);
    core_state = REQ; rd_en = 1'b1; wr_en = 1'b1;
    @(negedge clk);
    core_state = 3'd0; rd_en = 1'b0; wr_en = 1'b0;
    exp_err = 1'b1;
    check("illegal_state", 32'(lsu_state), 4);
    check("illegal_err", 32'(lsu_error), 32'(exp_err));
    repeat (4) begin
      check("illegal_novalid", 32'(bus.mem_read_valid | bus.mem_write_valid), 0);
      @(negedge clk);
    end
    core_state = UPD;
    @(negedge clk);
    core_state = 3'd0;
    check("illegal_idle", 32'(lsu_state), 0);
    check("illegal_err_persist", 32'(lsu_error), 32'(exp_err));

    for (int i = 0; i < 24; i++)
      do_op(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
            int'($urandom_range(0, 6)), DW'($urandom), 0);

    // Enable low for 5 cycles mid-WAITING with ready high: nothing moves, timeout still 4 enabled cycles.
    do_op(1'b0, 8'h60, 8'h00, 100, 8'h11, 2);

    // Reset mid-WAITING takes effect between clock edges.
    @(negedge clk);
    core_state = REQ; rd_en = 1'b1; wr_en = 1'b0; rs = 8'h77;
    @(negedge clk);
    core_state = 3'd0; rd_en = 1'b0;
    @(negedge clk);
    check("pre_rst_state", 32'(lsu_state), 2);
    check("pre_rst_valid", 32'(bus.mem_read_valid), 1);
    #2 reset = 1'b0;
    #1 check_all_zero("async_rst");
    exp_out = '0; exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_state", 32'(lsu_state), 0);
      check("post_rst_valid", 32'(bus.mem_read_valid | bus.mem_write_valid), 0);
    end
    do_op(1'b1, 8'h21, 8'hC3, 1, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
